// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result accumulator: result bit positions,
// FSM state encoding and the result-code legality check.
package cmp_pkg;

  localparam int CMP_LT_BIT  = 0;
  localparam int CMP_EQ_BIT  = 1;
  localparam int CMP_GT_BIT  = 2;
  localparam int CMP_RSV_BIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  // A legal code has the reserved bit clear and exactly one of LT/EQ/GT set.
  function automatic logic cmp_code_legal(input logic [3:0] code);
    logic onehot;
    onehot = (code[2:0] == 3'b001) || (code[2:0] == 3'b010) || (code[2:0] == 3'b100);
    return onehot && !code[CMP_RSV_BIT];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cmp_result_accumulator.sv
// Windowed accumulator of comparator results with a valid/ready summary output.
// Define CMP_ACC_ERR_CHECK_EN to add the illegal-code counter (err_cnt/err_flag).
//
// state | meaning
// IDLE  | waiting for start; counters hold the previous summary
// ACCUM | accepting one result per cycle until WIN results are taken
// DONE  | summary presented on out_valid until out_ready
module cmp_result_accumulator
  import cmp_pkg::*;
#(
  parameter int WIN   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmp_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [3:0]       last_r,
`ifdef CMP_ACC_ERR_CHECK_EN
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
`endif
  output logic             busy
);

  cmp_state_e       state_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;
  logic [3:0]       last_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic accept;
  logic clr;
  logic legal;
  logic final_beat;

  assign accept     = in_valid && (state_q == ACCUM);
  assign clr        = start && (state_q == IDLE);
  assign legal      = cmp_code_legal(cmp_r);
  assign final_beat = accept && (idx_q == CNT_W'(WIN - 1));
  assign idx_d      = idx_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            idx_q  <= idx_d;
            last_q <= cmp_r;
            if (final_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // A start arriving with the handshake is dropped; it must be re-issued in IDLE.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && legal && cmp_r[CMP_LT_BIT]),
    .q     (lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && legal && cmp_r[CMP_EQ_BIT]),
    .q     (eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && legal && cmp_r[CMP_GT_BIT]),
    .q     (gt_cnt)
  );

`ifdef CMP_ACC_ERR_CHECK_EN
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && !legal),
    .q     (err_cnt)
  );

  assign err_flag = out_valid_q && (err_cnt != '0);
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign last_r    = last_q;

endmodule

// File: doc/cmp_result_accumulator.md
Name: cmp_result_accumulator

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Takes a stream of comparator result codes and accumulates per-window counts of A<B, A==B and A>B events.
- Presents a window summary with a valid/ready handshake to the next stage, such as a status register block or a display driver.
- Windowed FSM: collect WIN results, publish the summary, then hold it until the consumer accepts it.

Parameters:
- WIN, 8: results per window; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new window; honoured only in IDLE.
- in_valid  in  1  cmp_r carries a result this cycle.
- in_ready  out  1  block accepts a result this cycle.
- cmp_r  in  4  comparator result code: bit0 = A<B, bit1 = A==B, bit2 = A>B, bit3 = reserved (0).
- out_valid  out  1  summary valid.
- out_ready  in  1  consumer accepts the summary.
- lt_cnt  out  CNT_W  A<B count for the window.
- eq_cnt  out  CNT_W  A==B count.
- gt_cnt  out  CNT_W  A>B count.
- last_r  out  4  last accepted result code.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-low, independent of clk) drives:
  - state = IDLE
  - all counters = 0, last_r = 0
  - out_valid = 0, in_ready = 0, busy = 0
- Reset asserted mid-window discards the window; no summary is produced.
- IDLE:
  - in_ready = 0.
  - On start = 1: clear counters and the internal index, then go to ACCUM on the next edge.
- ACCUM:
  - in_ready = 1.
  - A result is accepted on an edge where in_valid & in_ready.
  - On accept: the counter selected by the set bit in cmp_r[2:0] increments by 1; last_r <= cmp_r; index++.
  - When the accepted result is number WIN (index == WIN-1 at accept), go to DONE on the same edge.
  - Counters update on that same edge.
  - No idle cycles are inserted between accepts; throughput is 1 result/cycle.
- DONE:
  - out_valid = 1, in_ready = 0.
  - lt_cnt/eq_cnt/gt_cnt/last_r are stable while out_valid = 1.
  - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
  - Counters hold their values in IDLE until the next start.
- start outside IDLE is ignored. start in the same cycle as the DONE handshake is also ignored; it must be re-issued in IDLE.
- Invariant at DONE: lt_cnt + eq_cnt + gt_cnt == WIN when every code is legal.
- Counters saturate at 2^CNT_W-1 and never wrap. This is unreachable for legal WIN but is still required.
- Illegal code (bit3 set, or cmp_r[2:0] not one-hot): the result is accepted and index advances, but no counter increments.
- Latency: the summary is visible on out_valid one cycle after the final accept edge.

Optional Feature:
- Macro CMP_ACC_ERR_CHECK_EN.
- When defined:
  - Adds output err_cnt (CNT_W) and output err_flag (1).
  - Each illegal code increments saturating err_cnt.
  - err_flag = (err_cnt != 0) during DONE.
  - err_cnt clears on start.
  - Reset value of both is 0.
- When undefined: the ports are absent and illegal codes are silently uncounted, as above.

Decomposition:
- Shared package cmp_pkg:
  - Result bit indices CMP_LT_BIT = 0, CMP_EQ_BIT = 1, CMP_GT_BIT = 2, CMP_RSV_BIT = 3.
  - State enum {IDLE, ACCUM, DONE}.
  - Helper function cmp_code_legal().
- One natural sub-module, sat_counter (parameter W; inputs clr and inc; output q, saturating). It is instantiated 3 times, plus once for err_cnt when CMP_ACC_ERR_CHECK_EN is defined.

Test Plan:
1. Reset mid-window:
   - Stimulus: WIN = 8; start, then 3 accepts (0001, 0100, 0010); assert rst_n = 0.
   - Response: every output is 0 immediately, without a clock edge; state is IDLE; no out_valid follows.
2. Full window mix:
   - Stimulus: start, then 8 back-to-back results 0001, 0100, 0100, 0001, 0010, 0001, 0001, 0010.
   - Response: out_valid one cycle after the 8th accept; lt = 4, eq = 2, gt = 2, last_r = 0010.
3. Upstream gaps and backpressure:
   - Stimulus: in_valid toggles 1, 0, 1, 0 across the window; out_ready held at 0 for 5 cycles after out_valid.
   - Response: only valid beats are counted; summary is stable and in_ready = 0 for all 5 cycles; IDLE one cycle after out_ready = 1.
4. Ignored starts:
   - Stimulus: start pulsed during ACCUM and during the DONE handshake cycle.
   - Response: counters unaffected; block ends in IDLE with busy = 0.
5. Illegal codes:
   - Stimulus: WIN = 4; codes 0011, 1000, 0010, 0000.
   - Response: eq = 1, lt = gt = 0; with CMP_ACC_ERR_CHECK_EN, err_cnt = 3 and err_flag = 1.
6. Saturation:
   - Stimulus: CNT_W = 2, WIN = 3, 3× code 0100.
   - Response: gt = 3 and holds; a forced 4th increment via the sat_counter unit test stays at 3.
